fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Fetch controller that sequences the CPU's 16-bit program counter register.
- Every cycle it decides whether the PC advances by 2, holds, or loads a redirect target.
- It runs a req/ack handshake to instruction memory and hands fetched instructions to decode over a valid/ready interface.
- Sits between the PC register, instruction memory and the decode/execute stages.

Parameters:
- ADDR_W, 16, width of PC and memory address.
- DATA_W, 16, instruction width.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  level; 1 = fetch, 0 = stop at next instruction boundary.
- pc_cur  input  ADDR_W  current PC register value.
- pc_load  output  1  1 = PC loads pc_target; 0 = PC increments by 2.
- pc_target  output  ADDR_W  value loaded into PC when pc_load=1.
- imem_req  output  1  instruction memory request.
- imem_addr  output  ADDR_W  request address.
- imem_ack  input  1  memory response; imem_rdata valid this cycle.
- imem_rdata  input  DATA_W  fetched instruction.
- inst_valid  output  1  instruction available to decode.
- inst_data  output  DATA_W  instruction to decode.
- inst_pc  output  ADDR_W  address of inst_data.
- inst_ready  input  1  decode accepts instruction.
- redirect  input  1  branch/jump taken, single-cycle pulse.
- redirect_target  input  ADDR_W  new PC; bit 0 ignored and forced 0.
- busy  output  1  state != IDLE.
- fetch_count  output  CNT_W  instructions handed to decode.

Behaviour:
- Hold/advance encoding: the PC increments on every clock unless loaded. The block therefore asserts pc_load=1 with pc_target=pc_cur to hold, and deasserts pc_load for exactly one cycle to advance.
- Reset (reset=0, asynchronous):
  - state=IDLE; imem_req=0; inst_valid=0; pending_redir=0; fetch_count=0; ir=0; ir_pc=0.
  - Outputs are decoded from registers, so pc_load=1 and pc_target=pc_cur during reset.
  - Reset asserted mid-handshake drops imem_req immediately; the memory side must tolerate an abandoned request.
- States: IDLE, FETCH, OUT.
- IDLE:
  - PC held.
  - redirect loads the target (pc_load=1, pc_target=redirect_target); used as the boot vector.
  - run=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc_cur, PC held.
  - The request stays asserted, with a stable address, until imem_ack.
  - redirect without ack: latch pending_redir=1 and pending_target; PC still held.
  - imem_ack with pending_redir or redirect in the same cycle:
    - Discard imem_rdata.
    - pc_load=1, pc_target = redirect_target if redirect, else pending_target (a same-cycle redirect is the newer one and wins).
    - Clear pending_redir.
    - Next state = FETCH if run=1, else IDLE.
  - imem_ack with no redirect: capture ir=imem_rdata and ir_pc=pc_cur, then go to OUT.
  - Minimum fetch latency is 1 cycle (ack in the first FETCH cycle).
- OUT:
  - inst_valid = !redirect; inst_data=ir; inst_pc=ir_pc.
  - redirect (priority over inst_ready): instruction squashed and not counted; PC loads target; next state FETCH if run=1, else IDLE.
  - inst_ready and no redirect:
    - pc_load=0 (PC += 2).
    - fetch_count += 1, wrapping modulo 2^CNT_W.
    - Next state FETCH if run=1, else IDLE.
  - Neither: hold in OUT, PC held.
- run=0 takes effect only at instruction boundaries (leaving OUT, or the discard path in FETCH). An outstanding request is never abandoned except by reset.
- PC wrap from 0xFFFE to 0x0000 belongs to the PC register; it is not special-cased here.
- Throughput: one instruction per 2 cycles with zero-wait memory and ready decode.

Test Plan:
- Reset with pc_cur=0, run=1, ack on every req, inst_ready=1 -> imem_addr sequence 0x0000, 0x0002, 0x0004; inst_valid every other cycle; fetch_count=3 after three handoffs.
- imem_ack delayed 3 cycles -> imem_req held 3 cycles with imem_addr constant and pc_load=1 throughout; instruction then presented with the correct inst_pc.
- inst_ready low for 4 cycles in OUT -> inst_valid/inst_data stable, PC unchanged, fetch_count unchanged; advances on the ready cycle.
- redirect to 0x0100 while in FETCH awaiting ack, ack 2 cycles later -> rdata discarded, no inst_valid, next imem_addr=0x0100; redirect and ack in the same cycle gives the same result.
- redirect to 0x0041 in OUT with inst_ready=1 -> inst_valid=0 that cycle, fetch_count unchanged, next imem_addr=0x0040.
- run dropped mid-request, then reset pulled low mid-request -> first case completes the handoff then returns to IDLE with busy=0; second case drops imem_req asynchronously and sets fetch_count=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch controller: drives the PC hold/advance/load controls, runs the imem
// req/ack handshake and presents fetched instructions to decode.
module fetch_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_cur,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              busy,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t            state;
    logic              pending_redir;
    logic [ADDR_W-1:0] pending_target;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] ir_pc;
    logic [ADDR_W-1:0] redir_aligned;

    assign redir_aligned = {redirect_target[ADDR_W-1:1], 1'b0};

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc_cur;
    assign inst_valid = (state == OUT) && !redirect;
    assign inst_data  = ir;
    assign inst_pc    = ir_pc;
    assign busy       = (state != IDLE);

    // The PC self-increments, so "hold" is a load of its own value.
    always_comb begin
        pc_load   = 1'b1;
        pc_target = pc_cur;
        unique case (state)
            IDLE: begin
                if (redirect)
                    pc_target = redir_aligned;
            end
            FETCH: begin
                if (imem_ack && (redirect || pending_redir))
                    pc_target = redirect ? redir_aligned : pending_target;
            end
            OUT: begin
                if (redirect)
                    pc_target = redir_aligned;
                else if (inst_ready)
                    pc_load = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pending_redir  <= 1'b0;
            pending_target <= '0;
            ir             <= '0;
            ir_pc          <= '0;
            fetch_count    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run)
                        state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (redirect || pending_redir) begin
                            pending_redir <= 1'b0;
                            state         <= run ? FETCH : IDLE;
                        end else begin
                            ir    <= imem_rdata;
                            ir_pc <= pc_cur;
                            state <= OUT;
                        end
                    end else if (redirect) begin
                        pending_redir  <= 1'b1;
                        pending_target <= redir_aligned;
                    end
                end
                OUT: begin
                    if (redirect) begin
                        state <= run ? FETCH : IDLE;
                    end else if (inst_ready) begin
                        fetch_count <= fetch_count + 1'b1;
                        state       <= run ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
